mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DW, default 16, data word width in bits.
REQ-002 Parameter AW, default 3, data-memory address width (8 words).
REQ-003 CLK  input  1  single system clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 p0_req, p0_we  input  1 each  processor port: request; 1=write, 0=read.
REQ-006 p0_addr  input  AW  processor port address.
REQ-007 p0_wdata  input  DW  processor port write data.
REQ-008 p0_gnt, p0_rvalid  output  1 each  processor port: grant pulse; read-data-valid pulse.
REQ-009 p0_rdata  output  DW  processor port read data.
REQ-010 p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata  same directions/widths  loader/debug port.
REQ-011 mem_addr  output  AW  address to data memory.
REQ-012 mem_we  output  1  memory write enable.
REQ-013 mem_wdata  output  DW  memory write data.
REQ-014 mem_rdata  input  DW  memory read data, synchronous (valid the cycle after address presented).
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, GRANT, RDWAIT.
REQ-017 IDLE: req sampled at clock edge; no req -> stay IDLE; any req -> latch winner's port id, we, addr, wdata into registers, go GRANT.
REQ-018 Arbitration: one req -> that port wins; both -> port != last_winner wins (round-robin); last_winner updated on every IDLE->GRANT transition.
REQ-019 GRANT (exactly 1 cycle): mem_addr/mem_we/mem_wdata driven from latched registers; winner's gnt=1; other gnt=0.
REQ-020 GRANT with latched we=1 -> mem_we=1 this cycle only, next state IDLE (write = 2 cycles from req sample).
REQ-021 GRANT with latched we=0 -> mem_we=0, next state RDWAIT.
REQ-022 RDWAIT (exactly 1 cycle): winner's rvalid=1; winner's rdata registered from mem_rdata at the RDWAIT->IDLE edge and held until next read for that port; next state IDLE.
REQ-023 Correction to REQ-022 timing: rvalid is asserted in RDWAIT and rdata equals mem_rdata combinationally during that cycle, then holds the captured value afterwards.
REQ-024 Requester holds req/we/addr/wdata stable until gnt seen, deasserts req the cycle after gnt; req high in a later IDLE cycle is a new transaction.
REQ-025 Request arriving during GRANT/RDWAIT is not lost if held; served at next IDLE per REQ-018.
REQ-026 Outside GRANT: mem_we=0; mem_addr/mem_wdata hold last values.
REQ-027 gnt and rvalid never high on both ports in the same cycle.
REQ-028 Latched inputs change during GRANT/RDWAIT have no effect on current transaction.

Reset
REQ-029 RESET low: state=IDLE, last_winner=port1 (port0 wins first tie), all gnt/rvalid/mem_we/busy=0, mem_addr=0, mem_wdata=0, p0_rdata=p1_rdata=0 -- immediately, independent of CLK.
REQ-030 Reset during GRANT aborts transaction: mem_we drops asynchronously; reset during RDWAIT suppresses rvalid; no rdata update.
REQ-031 First transaction may start at first rising edge after RESET deasserts.

Structure
REQ-032 Shared package computer_pkg holds DW, AW defaults and the FSM state encoding (IDLE=2'b00, GRANT=2'b01, RDWAIT=2'b10).
REQ-033 One sub-module, rr_arbiter2: inputs two reqs + last_winner, output one-hot winner; combinational, instantiated once.

Verification
REQ-034 Reset: RESET=0 mid-simulation with p0 write in GRANT -> mem_we falls same time step; all outputs 0; busy=0.
REQ-035 Single write: p0 write addr 3 data 16'd6 -> p0_gnt and mem_we high one cycle 1 cycle after req; mem[3]=6; busy high 1 cycle.
REQ-036 Single read: after REQ-035, p0 read addr 3 -> gnt in cycle t+1, p0_rvalid in t+2 with p0_rdata=6; p0_rdata holds 6 afterwards.
REQ-037 Tie: p0 and p1 both request from reset (p0 write addr 1 data 1, p1 write addr 2 data 2) -> p0 granted first, p1 next; mem[1]=1, mem[2]=2; gnt never simultaneous.
REQ-038 Round-robin: both ports hold req continuously for 6 transactions -> grants alternate p0,p1,p0,p1,p0,p1.
REQ-039 Read-after-write hazard: p1 write addr 5 data 16'hABCD, then p0 read addr 5 -> p0_rdata=16'hABCD, p1_rvalid stays 0.

Source files
------------

// File: rtl/computer_pkg.sv
// Shared defaults and FSM encoding for the two-port data-memory arbiter.
package computer_pkg;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT  = 2'b01,
    RDWAIT = 2'b10
  } state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick; on a tie the port that did not win last time goes.
module rr_arbiter2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_winner,
  output logic [1:0] win
);
  always_comb begin
    win = 2'b00;
    if (req0 && req1) win = last_winner ? 2'b01 : 2'b10;
    else if (req0)    win = 2'b01;
    else if (req1)    win = 2'b10;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a processor port and a loader/debug port onto one synchronous data memory.
module mem_arbiter
  import computer_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          port_q, port_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic          mem_we_q, mem_we_d, busy_q, busy_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]    win;

  rr_arbiter2 u_arb (
    .req0        (p0_req),
    .req1        (p1_req),
    .last_winner (last_q),
    .win         (win)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    gnt_d    = 2'b00;
    rvalid_d = 2'b00;
    mem_we_d = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: if (win != 2'b00) begin
        state_d  = GRANT;
        port_d   = win[1];
        last_d   = win[1];
        we_d     = win[1] ? p1_we    : p0_we;
        addr_d   = win[1] ? p1_addr  : p0_addr;
        wdata_d  = win[1] ? p1_wdata : p0_wdata;
        gnt_d    = win;
        mem_we_d = we_d;
      end
      GRANT: begin
        state_d = we_q ? IDLE : RDWAIT;
        if (!we_q) rvalid_d = port_q ? 2'b10 : 2'b01;
      end
      RDWAIT: begin
        state_d = IDLE;
        if (port_q) rdata1_d = mem_rdata;
        else        rdata0_d = mem_rdata;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      mem_we_q <= 1'b0;
      busy_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      mem_we_q <= mem_we_d;
      busy_q   <= busy_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Latched address/data only move on IDLE->GRANT, so they double as the held memory bus.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;
  assign p0_gnt    = gnt_q[0];
  assign p1_gnt    = gnt_q[1];
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  // Read data flows through during RDWAIT and is held from the capture afterwards.
  assign p0_rdata  = (state_q == RDWAIT && !port_q) ? mem_rdata : rdata0_q;
  assign p1_rdata  = (state_q == RDWAIT &&  port_q) ? mem_rdata : rdata1_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus scoreboard of expected grants/read data.
module tb_mem_arbiter;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [2:0]  p0_addr = '0, p1_addr = '0;
  logic [15:0] p0_wdata = '0, p1_wdata = '0;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_we, busy;
  logic [15:0] p0_rdata, p1_rdata, mem_wdata;
  logic [2:0]  mem_addr;
  logic [15:0] mem_rdata = '0;
  logic [15:0] mem [8] = '{default: 16'h0};

  mem_arbiter #(.DW(16), .AW(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [2:0]  addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    int n0; bit w0; logic [2:0] a0; logic [15:0] d0;
    int n1; bit w1; logic [2:0] a1; logic [15:0] d1;
  } vec_t;

  exp_t        q[$];
  exp_t        rd_exp;
  bit          rd_pend = 0;
  bit          mon_en = 0;
  bit          last_m = 1;
  logic [15:0] ref_mem [8] = '{default: 16'h0};
  int          nvec = 0, nmis = 0;
  vec_t        vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: expected grant order and read data, in issue order.
  task automatic push(input bit port, input bit we, input logic [2:0] a, input logic [15:0] d);
    exp_t e;
    e.port = port; e.we = we; e.addr = a;
    if (we) begin e.data = d; ref_mem[a] = d; end
    else e.data = ref_mem[a];
    q.push_back(e);
    last_m = port;
  endtask

  always @(negedge CLK) if (mon_en) begin
    exp_t e;
    if (rd_pend) begin
      chk("rvalid_port", 32'({p1_rvalid, p0_rvalid}), rd_exp.port ? 32'd2 : 32'd1);
      chk("rdata", 32'(rd_exp.port ? p1_rdata : p0_rdata), 32'(rd_exp.data));
      rd_pend = 0;
    end else if (p0_rvalid || p1_rvalid)
      chk("stray_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
    if (p0_gnt || p1_gnt) begin
      chk("gnt_excl", 32'(p0_gnt & p1_gnt), 32'd0);
      chk("busy_in_grant", 32'(busy), 32'd1);
      if (q.size() == 0) chk("unexp_gnt", 32'({p1_gnt, p0_gnt}), 32'd0);
      else begin
        e = q.pop_front();
        chk("gnt_port", 32'({p1_gnt, p0_gnt}), e.port ? 32'd2 : 32'd1);
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
        else begin rd_pend = 1; rd_exp = e; end
      end
    end else chk("mem_we_idle", 32'(mem_we), 32'd0);
  end

  // Each port issues n requests; a port drops req as soon as it sees its last grant.
  task automatic run(input vec_t v);
    int c0 = v.n0, c1 = v.n1, r0 = v.n0, r1 = v.n1, cyc;
    bit w;
    while (c0 > 0 || c1 > 0) begin
      w = (c0 > 0 && c1 > 0) ? ~last_m : (c0 > 0 ? 1'b0 : 1'b1);
      if (w) begin push(1, v.w1, v.a1, v.d1); c1--; end
      else   begin push(0, v.w0, v.a0, v.d0); c0--; end
    end
    @(negedge CLK); #1;
    p0_req = (r0 > 0); p0_we = v.w0; p0_addr = v.a0; p0_wdata = v.d0;
    p1_req = (r1 > 0); p1_we = v.w1; p1_addr = v.a1; p1_wdata = v.d1;
    for (cyc = 0; cyc < 40 && (r0 > 0 || r1 > 0 || busy || rd_pend || q.size() > 0); cyc++) begin
      @(negedge CLK); #1;
      if (p0_gnt && r0 > 0) begin r0--; if (r0 == 0) p0_req = 0; end
      if (p1_gnt && r1 > 0) begin r1--; if (r1 == 0) p1_req = 0; end
    end
    if (cyc >= 40) begin
      chk("timeout", 32'(q.size()), 32'd0);
      q.delete(); p0_req = 0; p1_req = 0;
    end
    @(negedge CLK);
  endtask

  initial begin
    vt[0] = '{1, 1, 3'd1, 16'd1,      1, 1, 3'd2, 16'd2};
    vt[1] = '{0, 0, 3'd0, 16'd0,      1, 1, 3'd5, 16'hABCD};
    vt[2] = '{1, 0, 3'd5, 16'd0,      0, 0, 3'd0, 16'd0};
    vt[3] = '{3, 1, 3'd6, 16'h1111,   3, 1, 3'd7, 16'h2222};
    vt[4] = '{1, 0, 3'd1, 16'd0,      1, 0, 3'd2, 16'd0};
    vt[5] = '{0, 0, 3'd0, 16'd0,      1, 0, 3'd6, 16'd0};
    vt[6] = '{1, 1, 3'd0, 16'hFFFF,   1, 0, 3'd0, 16'd0};
    vt[7] = '{1, 0, 3'd7, 16'd0,      1, 0, 3'd0, 16'd0};

    #3 RESET = 0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'({p1_gnt, p0_gnt, p1_rvalid, p0_rvalid, mem_we}), 32'd0);
    chk("rst_mem_bus", 32'({mem_addr, mem_wdata}), 32'd0);
    chk("rst_rdata", 32'({p1_rdata, p0_rdata}), 32'd0);
    @(negedge CLK); RESET = 1;
    mon_en = 1;

    for (int i = 0; i < 8; i++) begin
      run(vt[i]);
      if (i == 0) begin
        chk("tie_mem1", 32'(mem[1]), 32'd1);
        chk("tie_mem2", 32'(mem[2]), 32'd2);
      end
    end

    // Cycle-exact single write then read on port 0.
    push(0, 1, 3'd3, 16'd6);
    @(negedge CLK); #1;
    p0_req = 1; p0_we = 1; p0_addr = 3'd3; p0_wdata = 16'd6;
    @(negedge CLK); #1;
    chk("wr_gnt", 32'({p0_gnt, mem_we, busy}), 32'h7);
    p0_req = 0;
    @(negedge CLK); #1;
    chk("wr_done", 32'({p0_gnt, mem_we, busy}), 32'h0);
    chk("wr_mem3", 32'(mem[3]), 32'd6);
    push(0, 0, 3'd3, 16'd0);
    p0_req = 1; p0_we = 0;
    @(negedge CLK); #1;
    chk("rd_gnt", 32'({p0_gnt, p0_rvalid}), 32'h2);
    p0_req = 0;
    @(negedge CLK); #1;
    chk("rd_valid", 32'({p0_rvalid, p0_rdata}), 32'h10006);
    @(negedge CLK); #1;
    chk("rd_hold", 32'({p0_rvalid, p0_rdata}), 32'h00006);
    run('{0, 0, 3'd0, 16'd0, 1, 1, 3'd3, 16'h5A5A});
    chk("rd_hold_p1wr", 32'(p0_rdata), 32'd6);

    // Asynchronous reset while a p0 write sits in GRANT.
    mon_en = 0;
    @(negedge CLK); #1;
    p0_req = 1; p0_we = 1; p0_addr = 3'd4; p0_wdata = 16'h1234;
    @(posedge CLK); #2;
    chk("pre_rst_we", 32'(mem_we), 32'd1);
    p0_req = 0;
    RESET = 0;
    #1;
    chk("rst_abort_we", 32'(mem_we), 32'd0);
    chk("rst_abort_all", 32'({p1_gnt, p0_gnt, p1_rvalid, p0_rvalid, busy}), 32'd0);
    chk("rst_abort_bus", 32'({mem_addr, mem_wdata}), 32'd0);
    chk("rst_abort_rd", 32'({p1_rdata, p0_rdata}), 32'd0);
    @(negedge CLK); RESET = 1;
    last_m = 1; rd_pend = 0; q.delete();
    mon_en = 1;
    chk("abort_mem4", 32'(mem[4]), 32'd0);
    run('{1, 0, 3'd4, 16'd0, 1, 0, 3'd5, 16'd0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
